srcnn_output_formatter: RTL and testbench

SRCNN_OUTPUT_FORMATTER -- requirements
Module: srcnn_output_formatter

---
 rtl/srcnn_output_formatter_pkg.sv | 39 +++
 rtl/srcnn_output_formatter_skid.sv | 69 ++++++
 rtl/srcnn_output_formatter.sv | 114 +++++++++++
 tb/tb_srcnn_output_formatter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/srcnn_output_formatter_pkg.sv
// Shared constants, pixel tag layout and the per-channel round/shift/saturate
// helper for the SRCNN output formatter.
package srcnn_output_formatter_pkg;

  localparam int PIXEL_WIDTH_DEFAULT = 8;

  typedef struct packed {
    logic eof;
    logic eol;
    logic sof;
  } pixel_tags_t;

  localparam int TAG_BITS = $bits(pixel_tags_t);

  // Rounds half-up at the binary point, drops the fraction and clamps into
  // [0, 2^pixel_width-1]. The 32-bit working width cannot overflow for any
  // activation narrower than 31 bits.
  function automatic logic [31:0] round_shift_sat(
    input logic signed [31:0] value,
    input int                 frac_bits,
    input int                 pixel_width
  );
    logic signed [31:0] rounded;
    logic signed [31:0] max_val;
    rounded = value;
    if (frac_bits > 0) begin
      rounded = value + (32'sd1 <<< (frac_bits - 1));
    end
    rounded = rounded >>> frac_bits;
    max_val = (32'sd1 <<< pixel_width) - 32'sd1;
    if (rounded < 32'sd0) begin
      return 32'd0;
    end else if (rounded > max_val) begin
      return $unsigned(max_val);
    end
    return $unsigned(rounded);
  endfunction

endpackage

// File: rtl/srcnn_output_formatter_skid.sv
// Two-entry valid/ready register pair: a registered main stage plus one skid
// entry, so the upstream ready is a flop and never sees the downstream ready.
module skid_buffer #(
  parameter int PayloadWidth = 8
) (
  input  logic                    clk,
  input  logic                    srst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [PayloadWidth-1:0] s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [PayloadWidth-1:0] m_data
);

  logic                    main_valid_reg, main_valid_next;
  logic [PayloadWidth-1:0] main_data_reg, main_data_next;
  logic                    skid_valid_reg, skid_valid_next;
  logic [PayloadWidth-1:0] skid_data_reg, skid_data_next;
  logic                    s_ready_reg;
  logic                    s_fire;
  logic                    main_free;

  assign s_fire    = s_valid && s_ready_reg;
  assign main_free = !main_valid_reg || m_ready;

  always_comb begin
    main_valid_next = main_valid_reg;
    main_data_next  = main_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    if (main_free) begin
      if (skid_valid_reg) begin
        // Older skid entry always drains first to keep pixel order.
        main_valid_next = 1'b1;
        main_data_next  = skid_data_reg;
        skid_valid_next = s_fire;
        skid_data_next  = s_fire ? s_data : skid_data_reg;
      end else begin
        main_valid_next = s_fire;
        main_data_next  = s_fire ? s_data : main_data_reg;
      end
    end else if (s_fire) begin
      skid_valid_next = 1'b1;
      skid_data_next  = s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      main_valid_reg <= 1'b0;
      main_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      s_ready_reg    <= 1'b0;
    end else begin
      main_valid_reg <= main_valid_next;
      main_data_reg  <= main_data_next;
      skid_valid_reg <= skid_valid_next;
      skid_data_reg  <= skid_data_next;
      s_ready_reg    <= !skid_valid_next;
    end
  end

  assign s_ready = s_ready_reg;
  assign m_valid = main_valid_reg;
  assign m_data  = main_data_reg;

endmodule

// File: rtl/srcnn_output_formatter.sv
// Converts signed fixed-point RGB activations into clamped unsigned pixels and
// tags them with SOF/EOL/EOF from row/column counters, behind a skid buffer.
module srcnn_output_formatter
  import srcnn_output_formatter_pkg::*;
#(
  parameter int Height          = 600,
  parameter int Width           = 800,
  parameter int ActivationWidth = 10,
  parameter int FractionBits    = 1,
  parameter int PixelWidth      = PIXEL_WIDTH_DEFAULT
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         slave_valid_i,
  output logic                         slave_ready_o,
  input  logic [3*ActivationWidth-1:0] slave_data_i,
  output logic                         master_valid_o,
  input  logic                         master_ready_i,
  output logic [3*PixelWidth-1:0]      master_data_o,
  output logic                         master_user_o,
  output logic                         master_last_o,
  output logic                         frame_done_o
);

  localparam int PayloadWidth = 3 * PixelWidth + TAG_BITS;
  localparam int ColW = (Width > 1) ? $clog2(Width) : 1;
  localparam int RowW = (Height > 1) ? $clog2(Height) : 1;
  localparam logic [ColW-1:0] ColLast = ColW'(Width - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(Height - 1);

  logic [ColW-1:0]         col_reg, col_next;
  logic [RowW-1:0]         row_reg, row_next;
  logic                    s_fire;
  logic [3*PixelWidth-1:0] pix_data;
  pixel_tags_t             tags_in, tags_out;
  logic [PayloadWidth-1:0] in_payload, out_payload;
  logic                    frame_done_reg;

  assign s_fire = slave_valid_i && slave_ready_o;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic [ActivationWidth-1:0] raw;
      logic signed [31:0]         ext;
      assign raw = slave_data_i[gi*ActivationWidth +: ActivationWidth];
      assign ext = {{(32 - ActivationWidth){raw[ActivationWidth-1]}}, raw};
      assign pix_data[gi*PixelWidth +: PixelWidth] =
        PixelWidth'(round_shift_sat(ext, FractionBits, PixelWidth));
    end
  endgenerate

  // Tags reflect the position of the pixel being accepted this cycle.
  always_comb begin
    tags_in     = '0;
    tags_in.sof = (row_reg == '0) && (col_reg == '0);
    tags_in.eol = (col_reg == ColLast);
    tags_in.eof = (col_reg == ColLast) && (row_reg == RowLast);
  end

  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (s_fire) begin
      if (col_reg == ColLast) begin
        col_next = '0;
        row_next = (row_reg == RowLast) ? '0 : row_reg + RowW'(1);
      end else begin
        col_next = col_reg + ColW'(1);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      col_reg <= '0;
      row_reg <= '0;
    end else begin
      col_reg <= col_next;
      row_reg <= row_next;
    end
  end

  assign in_payload = {tags_in, pix_data};

  skid_buffer #(
    .PayloadWidth(PayloadWidth)
  ) u_skid (
    .clk     (clock_i),
    .srst_n  (reset_i),
    .s_valid (slave_valid_i),
    .s_ready (slave_ready_o),
    .s_data  (in_payload),
    .m_valid (master_valid_o),
    .m_ready (master_ready_i),
    .m_data  (out_payload)
  );

  assign tags_out      = pixel_tags_t'(out_payload[PayloadWidth-1 -: TAG_BITS]);
  assign master_data_o = out_payload[3*PixelWidth-1:0];
  assign master_user_o = tags_out.sof;
  assign master_last_o = tags_out.eol;

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= master_valid_o && master_ready_i && tags_out.eof;
    end
  end

  assign frame_done_o = frame_done_reg;

endmodule

// File: tb/tb_srcnn_output_formatter.sv
// Directed and randomised checks of the output formatter with a 4x2 frame.
module tb_srcnn_output_formatter;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 10;
  localparam int PW = 8;

  logic            clock_i;
  logic            reset_i;
  logic            slave_valid_i;
  logic            slave_ready_o;
  logic [3*AW-1:0] slave_data_i;
  logic            master_valid_o;
  logic            master_ready_i;
  logic [3*PW-1:0] master_data_o;
  logic            master_user_o;
  logic            master_last_o;
  logic            frame_done_o;

  srcnn_output_formatter #(
    .Height(H), .Width(W), .ActivationWidth(AW), .FractionBits(1), .PixelWidth(PW)
  ) dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .slave_valid_i  (slave_valid_i),
    .slave_ready_o  (slave_ready_o),
    .slave_data_i   (slave_data_i),
    .master_valid_o (master_valid_o),
    .master_ready_i (master_ready_i),
    .master_data_o  (master_data_o),
    .master_user_o  (master_user_o),
    .master_last_o  (master_last_o),
    .frame_done_o   (frame_done_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  typedef struct packed {
    logic [AW-1:0] c2, c1, c0;
    logic [PW-1:0] e2, e1, e0;
  } vec_t;

  typedef struct packed {
    logic [3*PW-1:0] data;
    logic            sof, eol, eof;
  } exp_pix_t;

  int n_cmp = 0;
  int n_bad = 0;
  exp_pix_t exp_q[$];
  int row_m = 0, col_m = 0;
  logic exp_fd = 1'b0;
  logic hold_pending = 1'b0;
  logic [3*PW-1:0] held_data;
  logic held_user, held_last;
  int pix_idx = 0, n_acc = 0, n_out = 0, n_fd = 0, cyc = 0;
  int first_out_cyc = -1, last_out_cyc = -1;
  logic auto_data = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] model_ch(input logic [AW-1:0] raw);
    int a;
    a = int'($signed(raw)) + 1;
    a = a >>> 1;
    if (a < 0) return 8'd0;
    if (a > 255) return 8'd255;
    return a[7:0];
  endfunction

  function automatic logic [3*AW-1:0] gen_data(input int idx);
    logic [3*AW-1:0] d;
    for (int c = 0; c < 3; c++) begin
      int v;
      v = ((idx * 37 + c * 211 + 13) % 1024) - 512;
      d[c*AW +: AW] = AW'(v);
    end
    return d;
  endfunction

  function automatic vec_t mk(input int a, input int b, input int c,
                              input int x, input int y, input int z);
    vec_t v;
    v.c0 = AW'(a); v.c1 = AW'(b); v.c2 = AW'(c);
    v.e0 = PW'(x); v.e1 = PW'(y); v.e2 = PW'(z);
    return v;
  endfunction

  // One clock cycle seen from the negedge: score transfers, then advance.
  task automatic tick();
    logic s_fire, m_fire;
    exp_pix_t e, p;
    s_fire = slave_valid_i && slave_ready_o;
    m_fire = master_valid_o && master_ready_i;
    e = '0;
    chk("frame_done", {63'd0, frame_done_o}, {63'd0, exp_fd});
    if (frame_done_o) n_fd++;
    if (hold_pending) begin
      chk("hold_valid", {63'd0, master_valid_o}, 64'd1);
      chk("hold_data", {40'd0, master_data_o}, {40'd0, held_data});
      chk("hold_user", {63'd0, master_user_o}, {63'd0, held_user});
      chk("hold_last", {63'd0, master_last_o}, {63'd0, held_last});
    end
    if (m_fire) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_output: got %0h expected none", master_data_o);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", {40'd0, master_data_o}, {40'd0, e.data});
        chk("out_user", {63'd0, master_user_o}, {63'd0, e.sof});
        chk("out_last", {63'd0, master_last_o}, {63'd0, e.eol});
      end
      n_out++;
      if (first_out_cyc < 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
    end
    hold_pending = master_valid_o && !master_ready_i;
    held_data = master_data_o;
    held_user = master_user_o;
    held_last = master_last_o;
    if (s_fire) begin
      p.data = {model_ch(slave_data_i[2*AW +: AW]), model_ch(slave_data_i[AW +: AW]),
                model_ch(slave_data_i[0 +: AW])};
      p.sof = (row_m == 0) && (col_m == 0);
      p.eol = (col_m == W - 1);
      p.eof = p.eol && (row_m == H - 1);
      exp_q.push_back(p);
      if (col_m == W - 1) begin
        col_m = 0;
        row_m = (row_m == H - 1) ? 0 : row_m + 1;
      end else begin
        col_m++;
      end
      pix_idx++;
      n_acc++;
    end
    exp_fd = m_fire && e.eof;
    @(posedge clock_i);
    @(negedge clock_i);
    cyc++;
    if (auto_data) slave_data_i = gen_data(pix_idx);
  endtask

  task automatic do_reset();
    reset_i = 1'b0;
    slave_valid_i = 1'b0;
    @(posedge clock_i);
    @(negedge clock_i);
    chk("rst_mvalid", {63'd0, master_valid_o}, 64'd0);
    chk("rst_sready", {63'd0, slave_ready_o}, 64'd0);
    chk("rst_fdone", {63'd0, frame_done_o}, 64'd0);
    chk("rst_data", {40'd0, master_data_o}, 64'd0);
    chk("rst_user", {62'd0, master_user_o, master_last_o}, 64'd0);
    exp_q.delete();
    row_m = 0; col_m = 0;
    exp_fd = 1'b0;
    hold_pending = 1'b0;
    reset_i = 1'b1;
    @(posedge clock_i);
    @(negedge clock_i);
    chk("rst_release_sready", {63'd0, slave_ready_o}, 64'd1);
  endtask

  vec_t vecs[6];

  initial begin
    int o0, a0, f0;
    vecs[0] = mk(101, -5, 511, 51, 0, 255);
    vecs[1] = mk(2, 3, -1, 1, 2, 0);
    vecs[2] = mk(-512, 0, 1, 0, 0, 1);
    vecs[3] = mk(510, 509, 508, 255, 255, 254);
    vecs[4] = mk(100, 101, 0, 50, 51, 0);
    vecs[5] = mk(1, -1, -2, 1, 0, 0);

    reset_i = 1'b0;
    slave_valid_i = 1'b0;
    master_ready_i = 1'b0;
    slave_data_i = '0;
    @(negedge clock_i);
    do_reset();

    // Table-driven arithmetic vectors, one pixel at a time.
    master_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      slave_data_i = {vecs[i].c2, vecs[i].c1, vecs[i].c0};
      slave_valid_i = 1'b1;
      tick();
      slave_valid_i = 1'b0;
      chk("vec_latency", {63'd0, master_valid_o}, 64'd1);
      chk("vec_data", {40'd0, master_data_o}, {40'd0, vecs[i].e2, vecs[i].e1, vecs[i].e0});
      tick();
      chk("vec_idle", {63'd0, master_valid_o}, 64'd0);
    end

    // Full frame streamed with downstream always ready.
    do_reset();
    auto_data = 1'b1;
    slave_data_i = gen_data(pix_idx);
    master_ready_i = 1'b1;
    slave_valid_i = 1'b1;
    o0 = n_out; f0 = n_fd; first_out_cyc = -1;
    for (int i = 0; i < 8; i++) tick();
    slave_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("stream_count", 64'(n_out - o0), 64'd8);
    chk("stream_consecutive", 64'(last_out_cyc - first_out_cyc), 64'd7);
    chk("stream_fdone_count", 64'(n_fd - f0), 64'd1);

    // Downstream stall from idle: two accepts fill main and skid.
    do_reset();
    a0 = n_acc;
    master_ready_i = 1'b0;
    slave_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("stall_accepts", 64'(n_acc - a0), 64'd2);
    chk("stall_sready", {63'd0, slave_ready_o}, 64'd0);
    master_ready_i = 1'b1;
    for (int i = 0; i < 30 && (n_acc - a0) < 8; i++) tick();
    slave_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("stall_accepted", 64'(n_acc - a0), 64'd8);
    chk("stall_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-frame with pixels in flight.
    do_reset();
    a0 = n_acc;
    slave_valid_i = 1'b1;
    for (int i = 0; i < 20 && (n_acc - a0) < 5; i++) tick();
    master_ready_i = 1'b0;
    tick();
    tick();
    do_reset();
    chk("midrst_flushed", {63'd0, master_valid_o}, 64'd0);
    master_ready_i = 1'b1;
    slave_valid_i = 1'b1;
    tick();
    slave_valid_i = 1'b0;
    chk("midrst_sof", {63'd0, master_user_o}, 64'd1);
    for (int i = 0; i < 3; i++) tick();

    // Random valid/ready over three frames against the scoreboard.
    do_reset();
    a0 = n_acc; o0 = n_out; f0 = n_fd;
    for (int i = 0; i < 3000 && (n_out - o0) < 24; i++) begin
      slave_valid_i = ((n_acc - a0) < 24) && ($urandom_range(0, 9) < 7);
      master_ready_i = ($urandom_range(0, 9) < 6);
      tick();
    end
    slave_valid_i = 1'b0;
    master_ready_i = 1'b1;
    tick();
    tick();
    chk("rand_outputs", 64'(n_out - o0), 64'd24);
    chk("rand_frames", 64'(n_fd - f0), 64'd3);
    chk("rand_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
